// File: rtl/sram22_ctrl_pkg.sv
// Shared types and width helpers for the sram22 request front-end.
// Optional init sweep is enabled by defining SRAM22_CTRL_INIT_EN.
package sram22_ctrl_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Response FIFO holding read data until the consumer takes it.
// Pointers wrap modulo DEPTH, so non-power-of-two depths work.
module sram22_rsp_fifo
    import sram22_ctrl_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    localparam int CW        = cnt_bits(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full
);

    localparam int PW = ptr_bits(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= bump(wr_ptr);
            if (pop)
                rd_ptr <= bump(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/sram22_req_ctrl.sv
// Valid/ready front-end for one sram22 macro with credit-guarded reads.
// Define SRAM22_CTRL_INIT_EN to zero the macro after reset.
module sram22_req_ctrl
    import sram22_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4,
    parameter int RSP_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   busy,
    output logic                   sram_rstb,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int CW = cnt_bits(RSP_DEPTH);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] init_addr_q;
    logic                  run;
    logic                  fire;
    logic                  inflight_q;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           avail;

`ifdef SRAM22_CTRL_INIT_EN
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] init_addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        unique case (state_q)
            ST_INIT: begin
                init_addr_d = init_addr_q + 1'b1;
                if (&init_addr_q)
                    state_d = ST_RUN;
            end
            default: ;
        endcase
    end
`else
    assign state_q     = ST_RUN;
    assign init_addr_q = '0;
`endif

    assign run       = (state_q == ST_RUN) && !rst;
    assign busy      = (state_q == ST_INIT);
    assign sram_rstb = ~rst;

    // Every slot is either queued, in flight, or free; a pop frees one now.
    assign fifo_pop = rsp_valid && rsp_ready;
    assign avail    = (CW+1)'(RSP_DEPTH)
                    - (CW+1)'(fifo_count)
                    - (CW+1)'(inflight_q)
                    + (CW+1)'(fifo_pop);

    assign req_ready = run && (req_we || (avail != '0));
    assign fire      = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst)
            inflight_q <= 1'b0;
        else
            inflight_q <= fire && !req_we;
    end

    // The macro registers dout at the issue edge; it is stable one cycle later.
    assign fifo_push = inflight_q;

    always_comb begin
        sram_ce    = fire;
        sram_we    = req_we;
        sram_wmask = req_wmask;
        sram_addr  = req_addr;
        sram_din   = req_wdata;
        if (state_q == ST_INIT) begin
            sram_ce    = !rst;
            sram_we    = 1'b1;
            sram_wmask = '1;
            sram_addr  = init_addr_q;
            sram_din   = '0;
        end
    end

    sram22_rsp_fifo #(
        .DEPTH      (RSP_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (sram_dout),
        .rdata (rsp_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rsp_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_push && fifo_full));
            assert (!(fifo_pop && fifo_empty));
        end
    end

endmodule
